// File: rtl/if_pc_sequencer.sv
// Fetch-stage PC sequencer: picks the next IMEM address from reset,
// EX/ID redirects and stalls, and tags the fetched instruction for ID.
module if_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] id_redirect_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        id_kill,
  output logic        fetch_misaligned,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  logic [31:0] pc_q, pc_d;
  logic        v_q, v_d;
  logic        mis_q, mis_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] tgt_raw;
  logic        tgt_sel;

  always_comb begin
    tgt_raw = 32'd0;
    tgt_sel = 1'b0;
    pc_d    = pc_q + 32'd4;
    if (rst) begin
      pc_d = RESET_PC;
    end else if (ex_redirect) begin
      tgt_raw = ex_redirect_target;
      tgt_sel = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (id_redirect) begin
      tgt_raw = id_redirect_target;
      tgt_sel = 1'b1;
    end
    // Targets are word-aligned by dropping the low bits.
    if (tgt_sel) begin
      pc_d = {tgt_raw[31:2], 2'b00};
    end
  end

  always_comb begin
    v_d         = v_q | ex_redirect;
    mis_d       = mis_q | (tgt_sel & (tgt_raw[1:0] != 2'b00));
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (v_q & ~stall & ~ex_redirect) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (ex_redirect) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
    if (rst) begin
      v_d         = 1'b1;
      mis_d       = 1'b0;
      fetch_cnt_d = 32'd0;
      flush_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    pc_q        <= pc_d;
    v_q         <= v_d;
    mis_q       <= mis_d;
    fetch_cnt_q <= fetch_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign imem_addr        = pc_d;
  assign id_inst          = imem_rdata;
  assign id_pc            = pc_q;
  assign id_valid         = v_q & ~rst;
  assign id_kill          = ex_redirect & v_q & ~rst;
  assign fetch_misaligned = mis_q;
  assign fetch_count      = fetch_cnt_q;
  assign flush_count      = flush_cnt_q;

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Directed bench for if_pc_sequencer with a simple
// address-derived IMEM model.
module tb_if_pc_sequencer;

  localparam logic [31:0] K  = 32'h1357_9BDF;
  localparam logic [31:0] RB = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_redirect_target;
  logic        ex_redirect;
  logic [31:0] ex_redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_kill;
  logic        fetch_misaligned;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  int checks = 0;
  int failures = 0;

  if_pc_sequencer dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .id_redirect(id_redirect),
    .id_redirect_target(id_redirect_target),
    .ex_redirect(ex_redirect),
    .ex_redirect_target(ex_redirect_target),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .id_valid(id_valid),
    .id_kill(id_kill),
    .fetch_misaligned(fetch_misaligned),
    .fetch_count(fetch_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // IMEM: one-cycle read, data is the address xor a constant
  always @(posedge clk) imem_rdata <= imem_addr ^ K;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic idr, input logic [31:0] idt,
                       input logic exr, input logic [31:0] ext);
    @(negedge clk);
    rst = r;
    stall = s;
    id_redirect = idr;
    id_redirect_target = idt;
    ex_redirect = exr;
    ex_redirect_target = ext;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    id_redirect = 1'b0;
    id_redirect_target = 32'd0;
    ex_redirect = 1'b0;
    ex_redirect_target = 32'd0;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 32'h1234_5678);
    chk("rst_addr", imem_addr, RB);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_kill", {31'd0, id_kill}, 32'd0);

    drive(0, 0, 0, 0, 0, 0);
    chk("r0_pc", id_pc, RB);
    chk("r0_valid", {31'd0, id_valid}, 32'd1);
    chk("r0_inst", id_inst, RB ^ K);
    chk("r0_fetch", fetch_count, 32'd0);
    chk("r0_flush", flush_count, 32'd0);
    chk("r0_mis", {31'd0, fetch_misaligned}, 32'd0);
    chk("r0_addr", imem_addr, RB + 32'h4);

    drive(0, 0, 0, 0, 0, 0);
    chk("r1_pc", id_pc, 32'h4000_0004);
    drive(0, 0, 0, 0, 0, 0);
    chk("r2_pc", id_pc, 32'h4000_0008);
    chk("r2_inst", id_inst, 32'h4000_0008 ^ K);
    drive(0, 0, 0, 0, 0, 0);
    chk("r3_fetch", fetch_count, 32'd3);

    drive(0, 1, 0, 0, 0, 0);
    chk("st0_pc", id_pc, 32'h4000_0010);
    chk("st0_addr", imem_addr, 32'h4000_0010);
    chk("st0_fetch", fetch_count, 32'd4);
    drive(0, 1, 0, 0, 0, 0);
    chk("st1_pc", id_pc, 32'h4000_0010);
    chk("st1_addr", imem_addr, 32'h4000_0010);
    chk("st1_inst", id_inst, 32'h4000_0010 ^ K);
    chk("st1_fetch", fetch_count, 32'd4);
    drive(0, 0, 0, 0, 0, 0);
    chk("st2_fetch", fetch_count, 32'd4);
    chk("st2_addr", imem_addr, 32'h4000_0014);
    drive(0, 1, 1, 32'h4000_0100, 0, 0);
    chk("st_after_pc", id_pc, 32'h4000_0014);
    chk("sidr_addr", imem_addr, 32'h4000_0014);

    drive(0, 0, 1, 32'h4000_0100, 0, 0);
    chk("sidr_pc", id_pc, 32'h4000_0014);
    chk("idr_addr", imem_addr, 32'h4000_0100);
    chk("idr_kill", {31'd0, id_kill}, 32'd0);

    drive(0, 1, 1, 32'h4000_0100, 1, 32'h4000_0040);
    chk("idr_pc", id_pc, 32'h4000_0100);
    chk("idr_inst", id_inst, 32'h4000_0100 ^ K);
    chk("exr_addr", imem_addr, 32'h4000_0040);
    chk("exr_kill", {31'd0, id_kill}, 32'd1);
    chk("exr_fetch_pre", fetch_count, 32'd6);

    drive(0, 0, 0, 0, 0, 0);
    chk("exr_pc", id_pc, 32'h4000_0040);
    chk("exr_valid", {31'd0, id_valid}, 32'd1);
    chk("exr_flush", flush_count, 32'd1);
    chk("exr_fetch", fetch_count, 32'd6);
    chk("exr_kill_off", {31'd0, id_kill}, 32'd0);

    drive(0, 0, 1, 32'h4000_0102, 0, 0);
    chk("mis_addr", imem_addr, 32'h4000_0100);
    chk("mis_pre", {31'd0, fetch_misaligned}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("mis_pc", id_pc, 32'h4000_0100);
    chk("mis_set", {31'd0, fetch_misaligned}, 32'd1);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 0);
    chk("mis_hold", {31'd0, fetch_misaligned}, 32'd1);
    chk("mis_pc10", id_pc, 32'h4000_0128);
    chk("mis_fetch", fetch_count, 32'd18);

    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 0);
    chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    drive(0, 1, 0, 0, 0, 0);
    chk("wrap_pc0", id_pc, 32'h0000_0000);
    chk("wrap_inst", id_inst, K);

    drive(1, 1, 0, 0, 1, 32'h0000_0080);
    chk("mrst_addr", imem_addr, RB);
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_kill", {31'd0, id_kill}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("mrst_pc", id_pc, RB);
    chk("mrst_fetch", fetch_count, 32'd0);
    chk("mrst_flush", flush_count, 32'd0);
    chk("mrst_mis", {31'd0, fetch_misaligned}, 32'd0);
    chk("mrst_valid1", {31'd0, id_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_pc_sequencer.md
# if_pc_sequencer

Fetch-stage PC sequencer. It answers the ID-stage control signals: it holds the PC on a load-use `stall` and follows ID jump/branch target redirects. It also follows EX mispredict redirects. It drives the synchronous IMEM read address and presents each fetched instruction to the ID stage with its PC and a valid bit. It also keeps fetch and flush counters for the CSR block.

## Interface
Parameters:
- RESET_PC, 32'h4000_0000 — first instruction address after reset (BIOS base).

Ports:
- clk  in  1  — single clock; all state updates on rising edge.
- rst  in  1  — synchronous, active-high reset.
- stall  in  1  — ID load-use/store hazard stall from ID control.
- id_redirect  in  1  — ID target generator produced a taken target this cycle.
- id_redirect_target  in  32  — ID target address.
- ex_redirect  in  1  — EX branch mispredict.
- ex_redirect_target  in  32  — corrected address from EX.
- imem_addr  out  32  — IMEM read address, combinational; data returns the next cycle.
- imem_rdata  in  32  — IMEM data for the address presented the previous cycle.
- id_inst  out  32  — instruction in ID; equals imem_rdata.
- id_pc  out  32  — PC of id_inst.
- id_valid  out  1  — id_inst is a live instruction.
- id_kill  out  1  — ID instruction is squashed this cycle; ID/EX must load a bubble.
- fetch_misaligned  out  1  — sticky flag: a redirect target had bits [1:0] != 0.
- fetch_count  out  32  — count of instructions accepted out of ID.
- flush_count  out  32  — count of EX redirects.

## Operation
- State:
  - pc_q (32), PC of the instruction in ID.
  - v_q (1).
  - mis_q (1).
  - fetch_count and flush_count registers.
- next_pc selection, priority high to low:
  1. rst → RESET_PC
  2. ex_redirect → ex_redirect_target
  3. stall → pc_q
  4. id_redirect → id_redirect_target
  5. otherwise → pc_q + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0)
- Target bits [1:0] are forced to 2'b00 before use. If the selected target had nonzero low bits, mis_q is set and stays set until rst.
- imem_addr = next_pc. On each edge, pc_q ← next_pc.
- id_pc = pc_q. id_inst = imem_rdata. id_valid = v_q & ~rst.
- id_kill = ex_redirect & v_q.
- On ex_redirect, v_q ← 1; the target instruction is valid in ID the next cycle.
- Stall together with id_redirect: stall wins and the redirect is ignored. ID re-presents it after the stall clears.
- Stall together with ex_redirect: ex_redirect wins.
- Counter updates, each wrapping at 2^32:
  - fetch_count increments when v_q & ~stall & ~ex_redirect & ~rst.
  - flush_count increments on ex_redirect & ~rst.
- Reset:
  - pc_q ← RESET_PC, v_q ← 1, mis_q ← 0, both counters ← 0.
  - While rst is high: id_valid = 0, id_kill = 0, imem_addr = RESET_PC.
  - Reset asserted mid-stall or mid-redirect overrides everything in that cycle.

## Timing
- IMEM read latency is 1 cycle. An address driven in cycle t appears on imem_rdata in cycle t+1, in step with pc_q.
- The first post-reset cycle shows id_pc = RESET_PC with id_valid = 1.
- ID redirect: zero bubbles. The jump is in ID at cycle t and the target is in ID at t+1.
- EX redirect: one squashed ID slot (id_kill at cycle t). The target is in ID at t+1.
- Stall: pc_q and imem_addr hold (imem_addr = pc_q). id_inst is re-read and stays unchanged for the duration.
- All outputs except the counters are available within the cycle. imem_addr and id_kill are combinational from the inputs.

## Test plan
- Reset release, no redirects: id_pc = 4000_0000, 4000_0004, 4000_0008 on consecutive cycles; id_valid = 1; fetch_count = 3 after 3 cycles.
- stall held 2 cycles at pc_q = 4000_0010: imem_addr = 4000_0010 for both cycles; id_pc is stable; fetch_count does not advance; next cycle id_pc = 4000_0014.
- id_redirect to 4000_0100 at pc 4000_0008: next id_pc = 4000_0100; id_kill = 0. Same stimulus with stall = 1: the redirect is ignored and pc holds.
- ex_redirect to 4000_0040 together with stall and id_redirect to 4000_0100: imem_addr = 4000_0040; id_kill = 1; next id_pc = 4000_0040; flush_count += 1.
- id_redirect target 4000_0102: imem_addr = 4000_0100; fetch_misaligned = 1, still 1 after 10 cycles, cleared by rst.
- pc_q = FFFF_FFFC, no redirect: next imem_addr = 0000_0000. Then assert rst for 1 cycle mid-stall: imem_addr = 4000_0000, id_valid = 0, counters = 0.
